// File: rtl/can_tx_framer.sv
// CAN 2.0A base data frame transmitter: serialises one frame per start_tx with
// CRC-15, bit stuffing, arbitration-loss detection and ACK checking.
module can_tx_framer #(
  parameter int IFS_BITS  = 3,
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tx,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [7:0]  tx_data [0:7],
  input  logic        bit_tick,
  input  logic        rx_bit,
  output logic        tx_bit,
  output logic        busy,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        ack_err
);

  // state     | meaning
  // IDLE      | waiting for start_tx
  // LOAD      | frame latched, SOF goes out on next bit_tick
  // SEND      | serialising SOF..IFS, one bit per bit_tick
  // DONE      | one-cycle tx_done pulse
  // WAIT_IDLE | lost arbitration, waiting for IDLE_BITS recessive bits
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, WAIT_IDLE} state_t;

  localparam int ICW = $clog2(IDLE_BITS + 1);

  state_t          state;
  logic [10:0]     id_r;
  logic [3:0]      dlc_r;
  logic [63:0]     data_r;
  logic [14:0]     crc_r;
  logic [9:0]      pos;
  logic [2:0]      run_cnt;
  logic            stuffing;
  logic            ack_ok;
  logic [ICW-1:0]  idle_cnt;

  logic [6:0] n_data;
  logic [9:0] crc_start, crc_delim, ack_pos, last_pos, nxt_pos;
  logic [9:0] data_off, crc_off;
  logic       nxt_bit, in_arb, stuff_region;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic [14:0] s;
    s = {c[13:0], 1'b0};
    return (b ^ c[14]) ? (s ^ 15'h4599) : s;
  endfunction

  // Field boundaries follow from the latched DLC; dlc > 8 still carries 8 bytes.
  always_comb begin
    n_data    = dlc_r[3] ? 7'd64 : {1'b0, dlc_r[2:0], 3'b000};
    crc_start = 10'd19 + {3'b000, n_data};
    crc_delim = crc_start + 10'd15;
    ack_pos   = crc_start + 10'd16;
    last_pos  = crc_start + 10'(24 + IFS_BITS);
    nxt_pos   = pos + 10'd1;
    data_off  = nxt_pos - 10'd19;
    crc_off   = nxt_pos - crc_start;
    nxt_bit   = 1'b1;
    if (nxt_pos <= 10'd11)
      nxt_bit = id_r[4'(10'd11 - nxt_pos)];
    else if (nxt_pos <= 10'd14)
      nxt_bit = 1'b0;
    else if (nxt_pos <= 10'd18)
      nxt_bit = dlc_r[2'(10'd18 - nxt_pos)];
    else if (nxt_pos < crc_start)
      nxt_bit = data_r[6'(10'd63 - data_off)];
    else if (nxt_pos < crc_delim)
      nxt_bit = crc_r[4'(10'd14 - crc_off)];
    stuff_region = (pos < crc_delim);
    // A stuff bit keeps pos of the bit before it, so RTR-trailing stuff is excluded.
    in_arb = stuffing ? (pos >= 10'd1 && pos <= 10'd11)
                      : (pos >= 10'd1 && pos <= 10'd12);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_bit   <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      arb_lost <= 1'b0;
      ack_err  <= 1'b0;
      id_r     <= '0;
      dlc_r    <= '0;
      data_r   <= '0;
      crc_r    <= '0;
      pos      <= '0;
      run_cnt  <= '0;
      stuffing <= 1'b0;
      ack_ok   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      tx_done  <= 1'b0;
      arb_lost <= 1'b0;
      ack_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_tx) begin
            id_r   <= tx_id;
            dlc_r  <= tx_dlc;
            data_r <= {tx_data[0], tx_data[1], tx_data[2], tx_data[3],
                       tx_data[4], tx_data[5], tx_data[6], tx_data[7]};
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (bit_tick) begin
            tx_bit   <= 1'b0;
            pos      <= '0;
            run_cnt  <= 3'd1;
            stuffing <= 1'b0;
            crc_r    <= '0;
            ack_ok   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (bit_tick) begin
            if (in_arb && tx_bit && !rx_bit) begin
              arb_lost <= 1'b1;
              tx_bit   <= 1'b1;
              idle_cnt <= '0;
              state    <= WAIT_IDLE;
            end else if (pos == last_pos) begin
              tx_bit <= 1'b1;
              busy   <= 1'b0;
              if (ack_ok) begin
                tx_done <= 1'b1;
                state   <= DONE;
              end else begin
                state <= IDLE;
              end
            end else begin
              if (pos == ack_pos && rx_bit) begin
                ack_err <= 1'b1;
                ack_ok  <= 1'b0;
              end
              if (stuff_region && run_cnt == 3'd5) begin
                tx_bit   <= ~tx_bit;
                run_cnt  <= 3'd1;
                stuffing <= 1'b1;
              end else begin
                pos      <= nxt_pos;
                tx_bit   <= nxt_bit;
                stuffing <= 1'b0;
                run_cnt  <= (nxt_bit == tx_bit) ? run_cnt + 3'd1 : 3'd1;
                if (nxt_pos < crc_start)
                  crc_r <= crc_step(crc_r, nxt_bit);
              end
            end
          end
        end
        DONE: state <= IDLE;
        WAIT_IDLE: begin
          if (bit_tick) begin
            if (!rx_bit) begin
              idle_cnt <= '0;
            end else if (idle_cnt == ICW'(IDLE_BITS - 1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
